// File: rtl/vga_face_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_face_sequencer_if
//  Brief    : Board-side controls, snooped Avalon-ST handshake and the
//             face/filter selection outputs of the face sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface vga_face_sequencer_if;
    logic        btn_face;
    logic        btn_filter;
    logic        auto_en;
    logic        st_valid;
    logic        st_ready;
    logic        st_eop;
    logic [1:0]  face_select;
    logic [3:0]  filter_select;
    logic        pending;
    logic [15:0] frame_count;

    // Board I/O plus streamer handshake side
    modport master (
        output btn_face, btn_filter, auto_en, st_valid, st_ready, st_eop,
        input  face_select, filter_select, pending, frame_count
    );

    // Sequencer side
    modport slave (
        input  btn_face, btn_filter, auto_en, st_valid, st_ready, st_eop,
        output face_select, filter_select, pending, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_face_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_face_sequencer
//  Brief    : Selects face/filter for the 640x480 streamer. Button presses and
//             slideshow expiries are held pending and applied only on a frame
//             boundary (accepted end-of-packet), so no frame mixes settings.
//  Revision : 1.0  initial release
// ============================================================================
module vga_face_sequencer #(
    parameter int FRAMES_PER_FACE = 120,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_FACES       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_face_sequencer_if.slave  bus
);

    localparam int         c_DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int         c_AUTO_W    = (FRAMES_PER_FACE > 1) ? $clog2(FRAMES_PER_FACE) : 1;
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_AUTO_W-1:0] c_AUTO_LAST = c_AUTO_W'(FRAMES_PER_FACE - 1);
    localparam logic [1:0] c_LAST_FACE = 2'(NUM_FACES - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_ARMED = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_face_req;
    logic                r_filter_req;
    logic [1:0]          r_face;
    logic [3:0]          r_filter;
    logic [3:0]          w_filter_next;
    logic                r_pending;
    logic [15:0]         r_frame_count;
    logic [c_AUTO_W-1:0] r_auto_cnt;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;
    logic       w_frame_end;
    logic       w_auto_expire;
    logic       w_face_take;
    logic       w_filter_take;
    logic       w_apply;

    assign w_btn_raw = {bus.btn_filter, bus.btn_face};

    // Per button: 2-flop synchroniser, stability counter, rising-edge pulse.
    // Index 0 is the face button, index 1 the filter button.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]        r_sync;
            logic              r_stable;
            logic [c_DB_W-1:0] r_db_cnt;
            logic              r_pulse;

            // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync   <= 2'b00;
                    r_stable <= 1'b0;
                    r_db_cnt <= '0;
                    r_pulse  <= 1'b0;
                end else begin
                    r_sync  <= {r_sync[0], w_btn_raw[gi]};
                    r_pulse <= 1'b0;
                    if (r_sync[1] == r_stable) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_stable <= r_sync[1];
                        r_db_cnt <= '0;
                        r_pulse  <= r_sync[1];
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_pulse;
        end
    endgenerate

    assign w_frame_end   = bus.st_valid & bus.st_ready & bus.st_eop;
    assign w_auto_expire = bus.auto_en & w_frame_end & (r_auto_cnt == c_AUTO_LAST);

    // A request counts whether already latched or arriving this very cycle, so
    // a press landing on the frame_end edge is applied on that edge.
    assign w_face_take   = r_face_req | w_press[0] | w_auto_expire;
    assign w_filter_take = r_filter_req | w_press[1];
    assign w_apply       = w_frame_end & (r_state != S_APPLY) & (w_face_take | w_filter_take);

    // Next filter code in the fixed rotation
    always_comb begin
        w_filter_next = 4'b0000;
        case (r_filter)
            4'b0000: w_filter_next = 4'b0001;
            4'b0001: w_filter_next = 4'b0010;
            4'b0010: w_filter_next = 4'b0100;
            4'b0100: w_filter_next = 4'b0011;
            4'b0011: w_filter_next = 4'b1000;
            default: w_filter_next = 4'b0000;
        endcase
    end

    // Next-state decode for the pending/apply sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HOLD: begin
                if (w_apply)
                    w_next_state = S_APPLY;
                else if (w_face_take | w_filter_take)
                    w_next_state = S_ARMED;
            end
            S_ARMED: begin
                if (w_apply)
                    w_next_state = S_APPLY;
            end
            S_APPLY: begin
                w_next_state = (w_face_take | w_filter_take) ? S_ARMED : S_HOLD;
            end
            default: w_next_state = S_HOLD;
        endcase
    end

    // State register, requests, selections, pending flag and frame counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_HOLD;
            r_face_req    <= 1'b0;
            r_filter_req  <= 1'b0;
            r_face        <= 2'd0;
            r_filter      <= 4'b0000;
            r_pending     <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_state      <= w_next_state;
            r_face_req   <= w_face_take & ~w_apply;
            r_filter_req <= w_filter_take & ~w_apply;
            r_pending    <= (w_next_state == S_ARMED);
            if (w_apply && w_face_take)
                r_face <= (r_face == c_LAST_FACE) ? 2'd0 : r_face + 2'd1;
            if (w_apply && w_filter_take)
                r_filter <= w_filter_next;
            if (w_frame_end)
                r_frame_count <= r_frame_count + 16'd1;
        end
    end

    // Slideshow frame counter: idle when manual, restarts on any applied face change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_auto_cnt <= '0;
        end else if (!bus.auto_en || (w_apply && w_face_take)) begin
            r_auto_cnt <= '0;
        end else if (w_frame_end) begin
            r_auto_cnt <= (r_auto_cnt == c_AUTO_LAST) ? '0 : r_auto_cnt + 1'b1;
        end
    end

    assign bus.face_select   = r_face;
    assign bus.filter_select = r_filter;
    assign bus.pending       = r_pending;
    assign bus.frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_face_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_face_sequencer
//  Brief    : Directed self-checking bench for vga_face_sequencer using
//             16-cycle frames, 4-cycle debounce and 3 frames per face.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_face_sequencer;

    localparam int FRAME_LEN = 16;

    logic clk = 1'b0;
    logic reset;

    vga_face_sequencer_if bus();

    vga_face_sequencer #(
        .FRAMES_PER_FACE (3),
        .DEBOUNCE_CYCLES (4),
        .NUM_FACES       (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pix      = 0;
    logic [15:0] exp_frames = 16'd0;

    // One clock with the given handshake levels; returns 1 after the edge
    task automatic step(input logic valid, input logic ready, input logic eop);
        bus.st_valid = valid;
        bus.st_ready = ready;
        bus.st_eop   = eop;
        @(posedge clk);
        #1;
        if (valid && ready && eop)
            exp_frames = exp_frames + 16'd1;
    endtask

    // One always-accepted beat of the current frame
    task automatic beat();
        step(1'b1, 1'b1, pix == FRAME_LEN - 1);
        pix = (pix + 1) % FRAME_LEN;
    endtask

    task automatic finish_frame();
        do beat(); while (pix != 0);
    endtask

    // Hold buttons for the first half of a frame, then run the frame to its end
    task automatic press(input logic f, input logic fl);
        bus.btn_face   = f;
        bus.btn_filter = fl;
        repeat (8) beat();
        bus.btn_face   = 1'b0;
        bus.btn_filter = 1'b0;
        finish_frame();
    endtask

    task automatic check_face(input string name, input logic [1:0] exp);
        n_checks++;
        if (bus.face_select !== exp) begin
            n_errors++;
            $display("FAIL %s: face_select got %0d expected %0d", name, bus.face_select, exp);
        end
    endtask

    task automatic check_filter(input string name, input logic [3:0] exp);
        n_checks++;
        if (bus.filter_select !== exp) begin
            n_errors++;
            $display("FAIL %s: filter_select got %b expected %b", name, bus.filter_select, exp);
        end
    endtask

    task automatic check_pending(input string name, input logic exp);
        n_checks++;
        if (bus.pending !== exp) begin
            n_errors++;
            $display("FAIL %s: pending got %b expected %b", name, bus.pending, exp);
        end
    endtask

    task automatic check_count(input string name, input logic [15:0] exp);
        n_checks++;
        if (bus.frame_count !== exp) begin
            n_errors++;
            $display("FAIL %s: frame_count got %0d expected %0d", name, bus.frame_count, exp);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.btn_face   = 1'b0;
        bus.btn_filter = 1'b0;
        bus.auto_en    = 1'b0;
        bus.st_valid   = 1'b0;
        bus.st_ready   = 1'b0;
        bus.st_eop     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_face("reset_face", 2'd0);
        check_filter("reset_filter", 4'b0000);
        check_pending("reset_pending", 1'b0);
        check_count("reset_count", 16'd0);
        pix        = 0;
        exp_frames = 16'd0;
    endtask

    task automatic test_face_hold();
        repeat (2) beat();
        bus.btn_face = 1'b1;
        repeat (10) beat();
        bus.btn_face = 1'b0;
        repeat (3) beat();
        check_pending("hold_pending_midframe", 1'b1);
        check_face("hold_face_midframe", 2'd0);
        beat();
        check_face("hold_face_after_eop", 2'd1);
        check_pending("hold_pending_after_eop", 1'b0);
        finish_frame();
        check_face("hold_single_step", 2'd1);
        check_count("hold_frame_count", 16'd2);
    endtask

    task automatic test_filter_sequence();
        logic [3:0] seq [6];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b1000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            press(1'b0, 1'b1);
            check_filter($sformatf("filter_press_%0d", i), seq[i]);
            finish_frame();
            check_filter($sformatf("filter_idle_%0d", i), seq[i]);
        end
        check_face("filter_face_untouched", 2'd1);
    endtask

    task automatic test_reset_mid_run();
        press(1'b1, 1'b1);
        check_face("both_face", 2'd2);
        check_filter("both_filter", 4'b0001);
        repeat (3) press(1'b0, 1'b1);
        bus.btn_face = 1'b1;
        repeat (9) beat();
        bus.btn_face = 1'b0;
        repeat (5) beat();
        check_face("premid_face", 2'd2);
        check_filter("premid_filter", 4'b0011);
        check_pending("premid_pending", 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_face("async_reset_face", 2'd0);
        check_filter("async_reset_filter", 4'b0000);
        check_pending("async_reset_pending", 1'b0);
        check_count("async_reset_count", 16'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        pix        = 0;
        exp_frames = 16'd0;
        finish_frame();
        check_face("after_reset_discarded", 2'd0);
    endtask

    task automatic test_auto();
        logic [1:0] exp_face [10];
        exp_face = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        pix         = 0;
        exp_frames  = 16'd0;
        bus.auto_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            finish_frame();
            check_face($sformatf("auto_frame_%0d", k), exp_face[k]);
        end
        check_count("auto_frame_count", 16'd9);
    endtask

    task automatic test_auto_and_press();
        repeat (2) finish_frame();
        check_face("coinc_before", 2'd0);
        press(1'b1, 1'b0);
        check_face("coinc_single_step", 2'd1);
        check_pending("coinc_pending", 1'b0);
        repeat (2) finish_frame();
        check_face("coinc_restart", 2'd1);
        finish_frame();
        check_face("coinc_next_expiry", 2'd2);
        check_count("coinc_frame_count", 16'd15);
        bus.auto_en = 1'b0;
    endtask

    task automatic test_stall_eop();
        repeat (9) beat();
        bus.btn_face = 1'b1;
        repeat (6) beat();
        step(1'b1, 1'b0, 1'b1);
        check_face("stall_no_apply", 2'd2);
        check_pending("stall_pending", 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_face("novalid_no_apply", 2'd2);
        check_pending("novalid_pending", 1'b1);
        bus.btn_face = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        check_face("stall_applied", 2'd0);
        check_pending("stall_cleared", 1'b0);
        pix = 0;
        // Press pulse landing exactly on an accepted eop is applied there
        repeat (9) beat();
        bus.btn_face = 1'b1;
        repeat (7) beat();
        check_face("edge_press_applied", 2'd1);
        check_pending("edge_press_pending", 1'b0);
        bus.btn_face = 1'b0;
        finish_frame();
        check_face("edge_press_single", 2'd1);
        check_count("stall_frame_count", exp_frames);
    endtask

    task automatic test_random_frames();
        logic [1:0] hold_face;
        logic [3:0] hold_filter;
        int         changes;
        int         guard;
        bus.auto_en = 1'b1;
        hold_face   = bus.face_select;
        hold_filter = bus.filter_select;
        for (int fr = 0; fr < 1000; fr++) begin
            changes        = 0;
            bus.btn_face   = 1'($urandom_range(0, 1));
            bus.btn_filter = 1'($urandom_range(0, 1));
            for (int c = 0; c < FRAME_LEN - 1; c++) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
                if (bus.face_select !== hold_face || bus.filter_select !== hold_filter)
                    changes++;
            end
            guard = 0;
            bus.st_ready = 1'b0;
            while (!bus.st_ready && guard < 64) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
                if (!bus.st_ready &&
                    (bus.face_select !== hold_face || bus.filter_select !== hold_filter))
                    changes++;
                guard++;
            end
            n_checks++;
            if (changes != 0 || guard >= 64) begin
                n_errors++;
                $display("FAIL random_midframe_%0d: mid-frame changes got %0d expected 0 (eop tries %0d)",
                         fr, changes, guard);
            end
            hold_face   = bus.face_select;
            hold_filter = bus.filter_select;
        end
        bus.btn_face   = 1'b0;
        bus.btn_filter = 1'b0;
        check_count("random_frame_count", exp_frames);
    endtask

    initial begin
        test_reset();
        test_face_hold();
        test_filter_sequence();
        test_reset_mid_run();
        test_auto();
        test_auto_and_press();
        test_stall_eop();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
